alu_ctrl_muldiv: RTL

Parametrised successor to the single-cycle ALU control decoder. It keeps the combinational ALU_op/funct decode, extends the R-format table with NOR and SLT, and adds an iterative multiply/divide sequencer with HI/LO registers. While a MULT, MULTU, DIV or DIVU is in progress, the block raises a stall so the single-cycle datapath holds PC and register-file writes. It sits beside the main ALU, between the instruction decode and the register file.

---
 rtl/alu_ctrl_muldiv.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv
//   Purpose: combinational ALU control decode (ALU_op / funct) plus an
//   iterative multiply/divide sequencer with HI/LO result registers.
//   A MULT/MULTU/DIV/DIVU holds the single-cycle datapath through stall
//   until HI/LO have been written.
//
//   Ports:
//     clk, rst            rising-edge clock, synchronous active-high reset
//     valid               instruction on ALU_op/funct is live this cycle
//     ALU_op, funct       main-control op class and R-format funct field
//     rs_data, rt_data    dividend/multiplicand and divisor/multiplier
//     ALU_control_signal  combinational ALU opcode (zero-extended to CTRL_W)
//     illegal             combinational; undefined ALU_op/funct while valid
//     stall               hold PC and writeback while a mul/div runs
//     done                one-cycle pulse in the cycle HI/LO become visible
//     div_zero            sticky; the last divide had rt == 0
//     hi, lo              HI and LO registers
module alu_ctrl_muldiv #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [1:0]        ALU_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [CTRL_W-1:0] ALU_control_signal,
  output logic              illegal,
  output logic              stall,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            ctrl;
  logic                  bad, md, issue, sgn_in;
  logic [DATA_W-1:0]     mag_rs, mag_rt;
  logic [DATA_W-1:0]     mag_a, mag_b, rs_keep;
  logic                  op_div, b_zero, neg_q, neg_r;
  logic [2*DATA_W-1:0]   acc, acc_step, prod;
  logic [DATA_W:0]       mul_sum, div_sh, div_diff;
  logic [DATA_W-1:0]     q_fix, r_fix, res_hi, res_lo;

  // Magnitude of a two's-complement operand when the op is signed.
  // The most negative value maps to 2^(DATA_W-1), which is exact unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg_w(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg_2w(input logic [2*DATA_W-1:0] v,
                                                      input logic neg);
    return neg ? (~v + (2*DATA_W)'(1)) : v;
  endfunction

  always_comb begin
    ctrl = 4'b1000;
    bad  = 1'b0;
    md   = 1'b0;
    case (ALU_op)
      2'b00: ctrl = 4'b0010;
      2'b01: ctrl = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: ctrl = 4'b0010;
          6'b100010: ctrl = 4'b0110;
          6'b100100: ctrl = 4'b0000;
          6'b100101: ctrl = 4'b0001;
          6'b100111: ctrl = 4'b1100;
          6'b101010: ctrl = 4'b0111;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: md = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  assign ALU_control_signal = CTRL_W'(ctrl);
  assign illegal            = valid & bad;

  // The instruction stays presented during DONE, so only IDLE may issue.
  assign issue  = valid & md & (state == IDLE);
  assign sgn_in = ~funct[0];
  assign mag_rs = magnitude(rs_data, sgn_in);
  assign mag_rt = magnitude(rt_data, sgn_in);
  assign stall  = ~rst & ((state == BUSY) | issue);
  assign done   = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // One iteration. Multiply: acc = {partial product, remaining multiplier
  // bits}, add multiplicand when the LSB is set, then shift right.
  // Divide: acc = {remainder, dividend bits / quotient bits}, shift left
  // one bit, trial-subtract the divisor and keep the difference if it fits.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff = div_sh - {1'b0, mag_b};
    if (op_div) begin
      if (!div_diff[DATA_W]) acc_step = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else                   acc_step = {div_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[DATA_W-1:1]};
    end
  end

  // Sign fix-up applied to the final iteration's result on the HI/LO edge.
  always_comb begin
    prod  = cond_neg_2w(acc_step, neg_q);
    q_fix = cond_neg_w(acc_step[DATA_W-1:0], neg_q);
    r_fix = cond_neg_w(acc_step[2*DATA_W-1:DATA_W], neg_r);
    if (!op_div) begin
      res_hi = prod[2*DATA_W-1:DATA_W];
      res_lo = prod[DATA_W-1:0];
    end else if (b_zero) begin
      res_hi = rs_keep;
      res_lo = '1;
    end else begin
      res_hi = r_fix;
      res_lo = q_fix;
    end
  end

  // Issue edge: capture operands; not reset, only meaningful after an issue.
  always_ff @(posedge clk) begin
    if (issue) begin
      mag_a   <= mag_rs;
      mag_b   <= mag_rt;
      rs_keep <= rs_data;
      op_div  <= funct[1];
      b_zero  <= (rt_data == '0);
      neg_q   <= sgn_in & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
      neg_r   <= sgn_in & rs_data[DATA_W-1];
      acc     <= {{DATA_W{1'b0}}, (funct[1] ? mag_rs : mag_rt)};
    end else if (state == BUSY) begin
      acc     <= acc_step;
    end
  end

  // Iteration counter and architectural results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (issue) begin
      cnt      <= CNT_W'(DATA_W - 1);
      div_zero <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        hi       <= res_hi;
        lo       <= res_lo;
        div_zero <= op_div & b_zero;
      end
    end
  end

endmodule
